rf_write_arbiter: RTL and testbench

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_pkg.sv | 11 +
 rtl/rf_wr_slot.sv | 25 ++
 rtl/rf_write_arbiter.sv | 77 +++++++
 tb/tb_rf_write_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared widths, write-request struct and grant encoding for the RF write arbiter.
package rf_pkg;
   localparam int REG_ID_W = 4;
   localparam int DATA_W   = 16;
   localparam int NUM_REGS = 16;
   typedef struct packed {
      logic [REG_ID_W-1:0] rid;
      logic [DATA_W-1:0]   data;
   } wr_req_t;
   typedef enum logic { GNT_A = 1'b0, GNT_B = 1'b1 } gnt_t;
endpackage

// File: rtl/rf_wr_slot.sv
// rf_wr_slot: 1-entry holding slot; accepts on valid && ready and empties when drained.
module rf_wr_slot
   import rf_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    in_valid,
   input  wr_req_t in_req,
   input  logic    drain,
   output logic    ready,
   output logic    valid,
   output wr_req_t req
);
   // A drain in the same cycle frees the slot for an immediate refill.
   assign ready = !valid || drain;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         valid <= 1'b0;
         req   <= '0;
      end else if (in_valid && ready) begin
         valid <= 1'b1;
         req   <= in_req;
      end else if (drain)
         valid <= 1'b0;
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin merge of ALU and load writebacks onto one RF write port.
// Optional read bypass is built only when RF_WR_BYPASS_EN is defined.
module rf_write_arbiter
   import rf_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                a_valid,
   input  logic [REG_ID_W-1:0] a_reg,
   input  logic [DATA_W-1:0]   a_data,
   output logic                a_ready,
   input  logic                b_valid,
   input  logic [REG_ID_W-1:0] b_reg,
   input  logic [DATA_W-1:0]   b_data,
   output logic                b_ready,
   output logic                rf_wen,
   output logic [REG_ID_W-1:0] rf_reg,
   output logic [DATA_W-1:0]   rf_data,
   output logic [NUM_REGS-1:0] busy
`ifdef RF_WR_BYPASS_EN
   ,
   input  logic [REG_ID_W-1:0] rd1_reg,
   input  logic [REG_ID_W-1:0] rd2_reg,
   output logic                fwd1_hit,
   output logic                fwd2_hit,
   output logic [DATA_W-1:0]   fwd1_data,
   output logic [DATA_W-1:0]   fwd2_data
`endif
);
   gnt_t    last_grant;
   wr_req_t a_q, b_q, win;
   logic    a_occ, b_occ, a_gnt, b_gnt;
   // On a tie the slot not served last wins.
   assign a_gnt = a_occ && (!b_occ || last_grant == GNT_B);
   assign b_gnt = b_occ && (!a_occ || last_grant == GNT_A);
   assign win   = a_gnt ? a_q : b_q;
   rf_wr_slot u_slot_a (
      .clk(clk), .rst(rst), .in_valid(a_valid), .in_req('{rid: a_reg, data: a_data}),
      .drain(a_gnt), .ready(a_ready), .valid(a_occ), .req(a_q)
   );
   rf_wr_slot u_slot_b (
      .clk(clk), .rst(rst), .in_valid(b_valid), .in_req('{rid: b_reg, data: b_data}),
      .drain(b_gnt), .ready(b_ready), .valid(b_occ), .req(b_q)
   );
   // R0 is hardwired zero: its writes pass through the stage with the enable suppressed.
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         last_grant <= GNT_B;
         rf_wen     <= 1'b0;
         rf_reg     <= '0;
         rf_data    <= '0;
      end else begin
         rf_wen <= (a_gnt || b_gnt) && win.rid != '0;
         if (a_gnt || b_gnt) begin
            rf_reg     <= win.rid;
            rf_data    <= win.data;
            last_grant <= a_gnt ? GNT_A : GNT_B;
         end
      end
   always_comb begin
      busy = '0;
      for (int r = 1; r < NUM_REGS; r++)
         busy[r] = (a_occ && a_q.rid == REG_ID_W'(r)) || (b_occ && b_q.rid == REG_ID_W'(r))
                || (rf_wen && rf_reg == REG_ID_W'(r));
   end
`ifdef RF_WR_BYPASS_EN
   // The slot granted last is the younger one when both are pending.
   function automatic logic [DATA_W:0] lookup(input logic [REG_ID_W-1:0] rd);
      logic ha, hb;
      ha = a_occ && a_q.rid == rd;
      hb = b_occ && b_q.rid == rd;
      return {busy[rd], (ha && (!hb || last_grant == GNT_A)) ? a_q.data : hb ? b_q.data : rf_data};
   endfunction
   assign {fwd1_hit, fwd1_data} = lookup(rd1_reg);
   assign {fwd2_hit, fwd2_data} = lookup(rd2_reg);
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed and random checks against a queue-based model of the arbiter.
module tb_rf_write_arbiter;
   logic        clk = 1'b0, rst = 1'b0;
   logic        a_valid, b_valid, a_ready, b_ready, rf_wen;
   logic [3:0]  a_reg, b_reg, rf_reg;
   logic [15:0] a_data, b_data, rf_data, busy;
`ifdef RF_WR_BYPASS_EN
   logic [3:0]  rd1_reg = '0, rd2_reg = '0;
   logic        fwd1_hit, fwd2_hit;
   logic [15:0] fwd1_data, fwd2_data;
`endif
   rf_write_arbiter dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
      .rf_wen(rf_wen), .rf_reg(rf_reg), .rf_data(rf_data), .busy(busy)
`ifdef RF_WR_BYPASS_EN
      , .rd1_reg(rd1_reg), .rd2_reg(rd2_reg), .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
      .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
`endif
   );
   always #5 clk = ~clk;
   typedef struct {logic [3:0] id; logic [15:0] d;} wr_t;
   wr_t         qa[$], qb[$], wlog[$];
   bit          m_last_b = 1'b1, m_wen = 1'b0;
   logic [3:0]  m_reg = '0;
   logic [15:0] m_data = '0;
   int          n_chk = 0, n_pass = 0;
   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
   endtask
   function automatic bit m_ga();
      return qa.size() != 0 && (qb.size() == 0 || m_last_b);
   endfunction
   function automatic bit m_gb();
      return qb.size() != 0 && (qa.size() == 0 || !m_last_b);
   endfunction
   function automatic bit m_ra();
      return qa.size() == 0 || m_ga();
   endfunction
   function automatic bit m_rb();
      return qb.size() == 0 || m_gb();
   endfunction
   function automatic logic [15:0] m_busy();
      logic [15:0] b = '0;
      foreach (qa[i]) b[qa[i].id] = 1'b1;
      foreach (qb[i]) b[qb[i].id] = 1'b1;
      if (m_wen) b[m_reg] = 1'b1;
      b[0] = 1'b0;
      return b;
   endfunction
`ifdef RF_WR_BYPASS_EN
   function automatic logic [16:0] m_fwd(logic [3:0] rd);
      wr_t         ord[$];
      logic        hit = 1'b0;
      logic [15:0] d = '0;
      if (m_wen) ord.push_back('{m_reg, m_data});
      if (qa.size() != 0 && qb.size() != 0) begin
         ord.push_back(m_last_b ? qa[0] : qb[0]);
         ord.push_back(m_last_b ? qb[0] : qa[0]);
      end else begin
         foreach (qa[i]) ord.push_back(qa[i]);
         foreach (qb[i]) ord.push_back(qb[i]);
      end
      foreach (ord[i]) if (rd != 0 && ord[i].id == rd) begin hit = 1'b1; d = ord[i].d; end
      return {hit, d};
   endfunction
`endif
   task automatic step_model();
      bit ga = m_ga(), gb = m_gb(), ra = m_ra(), rb = m_rb();
      if (ga) begin
         m_wen = qa[0].id != 0; m_reg = qa[0].id; m_data = qa[0].d; void'(qa.pop_front()); m_last_b = 1'b0;
      end else if (gb) begin
         m_wen = qb[0].id != 0; m_reg = qb[0].id; m_data = qb[0].d; void'(qb.pop_front()); m_last_b = 1'b1;
      end else m_wen = 1'b0;
      if (a_valid && ra) qa.push_back('{a_reg, a_data});
      if (b_valid && rb) qb.push_back('{b_reg, b_data});
   endtask
   task automatic check_all();
`ifdef RF_WR_BYPASS_EN
      logic [16:0] f;
`endif
      chk("rf_wen", 32'(rf_wen), 32'(m_wen));
      if (m_wen) begin
         chk("rf_reg", 32'(rf_reg), 32'(m_reg));
         chk("rf_data", 32'(rf_data), 32'(m_data));
      end
      chk("busy", 32'(busy), 32'(m_busy()));
      chk("a_ready", 32'(a_ready), 32'(m_ra()));
      chk("b_ready", 32'(b_ready), 32'(m_rb()));
`ifdef RF_WR_BYPASS_EN
      f = m_fwd(rd1_reg);
      chk("fwd1_hit", 32'(fwd1_hit), 32'(f[16]));
      if (f[16]) chk("fwd1_data", 32'(fwd1_data), 32'(f[15:0]));
      f = m_fwd(rd2_reg);
      chk("fwd2_hit", 32'(fwd2_hit), 32'(f[16]));
      if (f[16]) chk("fwd2_data", 32'(fwd2_data), 32'(f[15:0]));
`endif
   endtask
   task automatic tick();
      @(posedge clk);
      step_model();
      #1;
      if (rf_wen) wlog.push_back('{rf_reg, rf_data});
      check_all();
   endtask
   task automatic drive(bit av, logic [3:0] ar, logic [15:0] ad, bit bv, logic [3:0] br, logic [15:0] bd);
      a_valid = av; a_reg = ar; a_data = ad;
      b_valid = bv; b_reg = br; b_data = bd;
   endtask
   task automatic model_reset();
      qa.delete(); qb.delete();
      m_last_b = 1'b1; m_wen = 1'b0; m_reg = '0; m_data = '0;
   endtask
   task automatic check_reset_outputs(string tag);
      chk({tag, "_wen"}, 32'(rf_wen), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_ardy"}, 32'(a_ready), 32'd1);
      chk({tag, "_brdy"}, 32'(b_ready), 32'd1);
   endtask
   initial begin
      drive(0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 check_reset_outputs("rst");
      #3 rst = 1'b1;
      // Contention: A wins the first tie after reset, then strict alternation.
      wlog.delete();
      drive(1, 4'd1, 16'h1111, 1, 4'd2, 16'h2222);
      repeat (9) tick();
      drive(0, 0, 0, 0, 0, 0);
      repeat (4) tick();
      chk("rr_count", 32'(wlog.size() >= 4), 32'd1);
      for (int i = 0; i < 4; i++)
         if (i < wlog.size()) chk("rr_order", 32'(wlog[i].id), (i % 2 == 0) ? 32'd1 : 32'd2);
      // Single write latency.
      drive(1, 4'd3, 16'h1234, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      chk("sw_busy_slot", 32'(busy[3]), 32'd1);
      chk("sw_wen_early", 32'(rf_wen), 32'd0);
      tick();
      chk("sw_wen", 32'(rf_wen), 32'd1);
      chk("sw_reg", 32'(rf_reg), 32'd3);
      chk("sw_data", 32'(rf_data), 32'h1234);
      chk("sw_busy_out", 32'(busy[3]), 32'd1);
      tick();
      chk("sw_wen_done", 32'(rf_wen), 32'd0);
      chk("sw_busy_done", 32'(busy[3]), 32'd0);
      // R0 writes are accepted but never enabled.
      wlog.delete();
      drive(0, 0, 0, 1, 4'd0, 16'hFFFF);
      chk("r0_ready", 32'(b_ready), 32'd1);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      repeat (3) begin
         tick();
         chk("r0_wen", 32'(rf_wen), 32'd0);
         chk("r0_busy", 32'(busy), 32'd0);
      end
      chk("r0_nowrite", 32'(wlog.size()), 32'd0);
      // Same destination from both ports lands in order.
      wlog.delete();
      drive(1, 4'd5, 16'h0001, 0, 0, 0);
      tick();
      drive(0, 0, 0, 1, 4'd5, 16'h0002);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      repeat (4) tick();
      chk("same_count", 32'(wlog.size()), 32'd2);
      if (wlog.size() == 2) begin
         chk("same_first", {12'd0, wlog[0].id, wlog[0].d}, 32'h0005_0001);
         chk("same_final", {12'd0, wlog[1].id, wlog[1].d}, 32'h0005_0002);
      end
`ifdef RF_WR_BYPASS_EN
      rd1_reg = 4'd7;
      drive(1, 4'd7, 16'hBEEF, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      chk("byp_hit_slot", 32'(fwd1_hit), 32'd1);
      chk("byp_data_slot", 32'(fwd1_data), 32'hBEEF);
      tick();
      chk("byp_hit_out", 32'(fwd1_hit), 32'd1);
      chk("byp_data_out", 32'(fwd1_data), 32'hBEEF);
      tick();
      chk("byp_hit_done", 32'(fwd1_hit), 32'd0);
`endif
      // Random traffic; a held-off request keeps its reg/data.
      for (int n = 0; n < 400; n++) begin
         if (!(a_valid && !m_ra())) begin
            a_valid = 1'($urandom_range(0, 1)); a_reg = 4'($urandom_range(0, 15)); a_data = 16'($urandom);
         end
         if (!(b_valid && !m_rb())) begin
            b_valid = 1'($urandom_range(0, 1)); b_reg = 4'($urandom_range(0, 15)); b_data = 16'($urandom);
         end
`ifdef RF_WR_BYPASS_EN
         rd1_reg = 4'($urandom_range(0, 15)); rd2_reg = 4'($urandom_range(0, 15));
`endif
         tick();
      end
      // Reset with both slots full.
      drive(1, 4'd4, 16'hAAAA, 1, 4'd6, 16'hBBBB);
      tick();
      tick();
      #2 rst = 1'b0;
      model_reset();
      #1 check_reset_outputs("midrst");
      repeat (2) @(posedge clk);
      #1 check_reset_outputs("inrst");
      drive(0, 0, 0, 0, 0, 0);
      #2 rst = 1'b1;
      wlog.delete();
      repeat (3) tick();
      chk("midrst_nowrite", 32'(wlog.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
